// File: rtl/sdram_port_arbiter.sv
// Three-master front end for the single-request SDRAM controller port.
// Video (port 0) has fixed priority with a starvation cap; ports 1/2 round-robin.
module sdram_port_arbiter #(
   parameter int ADDR_WIDTH   = 24,
   parameter int DATA_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic [DATA_WIDTH-1:0] wdata2,
   input  logic [1:0]            bsel0,
   input  logic [1:0]            bsel1,
   input  logic [1:0]            bsel2,
   output logic [2:0]            ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [1:0]            mem_bsel,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [1:0]            grant
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [1:0]            state_q,     state_d;
   logic [1:0]            rr_next_q,   rr_next_d;
   logic [3:0]            starve_q,    starve_d;
   logic [2:0]            ack_q,       ack_d;
   logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
   logic                  mem_req_q,   mem_req_d;
   logic                  mem_we_q,    mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]            mem_bsel_q,  mem_bsel_d;
   logic [1:0]            grant_q,     grant_d;

   logic                  competitor;
   logic [1:0]            winner;

   // Winner is only meaningful when at least one request is present.
   always_comb begin
      competitor = req[1] | req[2];
      if (req[0] && ((starve_q < LIMIT) || !competitor)) begin
         winner = 2'd0;
      end else if (req[rr_next_q]) begin
         winner = rr_next_q;
      end else begin
         winner = (rr_next_q == 2'd1) ? 2'd2 : 2'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_next_d   = rr_next_q;
      starve_d    = starve_q;
      ack_d       = '0;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_bsel_d  = mem_bsel_q;
      grant_d     = grant_q;

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               mem_req_d = 1'b1;
               grant_d   = winner;
               mem_we_d  = we[winner];
               state_d   = ST_BUSY;
               case (winner)
                  2'd0: begin
                     mem_addr_d  = addr0;
                     mem_wdata_d = wdata0;
                     mem_bsel_d  = bsel0;
                  end
                  2'd1: begin
                     mem_addr_d  = addr1;
                     mem_wdata_d = wdata1;
                     mem_bsel_d  = bsel1;
                  end
                  default: begin
                     mem_addr_d  = addr2;
                     mem_wdata_d = wdata2;
                     mem_bsel_d  = bsel2;
                  end
               endcase
               if (winner == 2'd0) begin
                  if (competitor) begin
                     starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
                  end else begin
                     starve_d = '0;
                  end
               end else begin
                  starve_d  = '0;
                  rr_next_d = (winner == 2'd1) ? 2'd2 : 2'd1;
               end
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               rdata_d   = mem_rdata;
               mem_req_d = 1'b0;
               ack_d     = 3'b001 << grant_q;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_next_q   <= 2'd1;
         starve_q    <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_bsel_q  <= '0;
         grant_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_next_q   <= rr_next_d;
         starve_q    <= starve_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_bsel_q  <= mem_bsel_d;
         grant_q     <= grant_d;
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_bsel  = mem_bsel_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_sdram_port_arbiter;

   localparam int AW  = 24;
   localparam int DW  = 16;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    req;
   logic [2:0]    we;
   logic [AW-1:0] pa [3];
   logic [DW-1:0] pd [3];
   logic [1:0]    pb [3];
   logic [2:0]    ack;
   logic [DW-1:0] rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    mem_bsel;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic [1:0]    grant;

   int total = 0;
   int bad   = 0;

   // model state: starvation count and round-robin pointer (port index)
   int m_starve;
   int m_rr;
   logic [DW-1:0] last_rd;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .addr0    (pa[0]),
      .addr1    (pa[1]),
      .addr2    (pa[2]),
      .wdata0   (pd[0]),
      .wdata1   (pd[1]),
      .wdata2   (pd[2]),
      .bsel0    (pb[0]),
      .bsel1    (pb[1]),
      .bsel2    (pb[2]),
      .ack      (ack),
      .rdata    (rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_bsel (mem_bsel),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .grant    (grant)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [2:0] r);
      bit comp;
      comp = r[1] | r[2];
      if (r[0] && (m_starve < LIM || !comp)) return 0;
      if (r[m_rr]) return m_rr;
      return 3 - m_rr;
   endfunction

   task automatic model_commit(input int w, input logic [2:0] r);
      if (w == 0) m_starve = (r[1] | r[2]) ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
      else begin
         m_starve = 0;
         m_rr     = (w == 1) ? 2 : 1;
      end
   endtask

   task automatic rand_ports();
      for (int i = 0; i < 3; i++) begin
         pa[i] = AW'($urandom);
         pd[i] = DW'($urandom);
         pb[i] = 2'($urandom_range(0, 3));
         we[i] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_mem(input string tag, input int g);
      check({tag, "_we"},    mem_we,    we[g]);
      check({tag, "_addr"},  mem_addr,  pa[g]);
      check({tag, "_wdata"}, mem_wdata, pd[g]);
      check({tag, "_bsel"},  mem_bsel,  pb[g]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = '0; mem_ack = 1'b0; reset = 1'b1;
      #1;
      check("rst_ack", ack, 0);       check("rst_rdata", rdata, 0);
      check("rst_mem_req", mem_req, 0); check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0); check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_bsel", mem_bsel, 0); check("rst_grant", grant, 0);
      @(negedge clk);
      reset = 1'b0;
      m_starve = 0; m_rr = 1; last_rd = '0;
   endtask

   // Presents r in IDLE; returns model winner and observed grant.
   task automatic start_txn(input logic [2:0] r, output int g, output int g_obs);
      @(negedge clk);
      req = r; mem_ack = 1'b0;
      g = model_pick(r);
      model_commit(g, r);
      @(posedge clk); #1;
      g_obs = int'(grant);
      check("grant", grant, g);
      check("mem_req_up", mem_req, 1);
      check("ack_busy", ack, 0);
      check_mem("issue", g);
   endtask

   task automatic finish_txn(input int g, input int lat, input bit drop, input logic [DW-1:0] rd);
      logic [2:0] e;
      e = 3'b001 << g;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         if (drop) req[g] = 1'b0;
         @(posedge clk); #1;
         check("busy_req", mem_req, 1);
         check("busy_ack", ack, 0);
         check_mem("hold", g);
      end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = rd;
      if (drop) req[g] = 1'b0;
      @(posedge clk); #1;
      check("ack", ack, e);
      check("rdata", rdata, rd);
      check("mem_req_down", mem_req, 0);
      last_rd = rd;
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = DW'($urandom);
      @(posedge clk); #1;
      check("ack_drop", ack, 0);
      check("rdata_hold", rdata, last_rd);
   endtask

   int g, go;
   int t2 [5]  = '{0, 1, 2, 1, 2};
   int t3 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      reset = 1'b1; req = '0; mem_ack = 1'b0; mem_rdata = '0;
      rand_ports();
      do_reset();

      // single CPU read
      pa[1] = 24'h000100; we[1] = 1'b0;
      start_txn(3'b010, g, go);
      check("t1_addr", mem_addr, 24'h000100);
      check("t1_we", mem_we, 0);
      finish_txn(g, 2, 1'b1, 16'hBEEF);

      // simultaneous requests, then port 0 drops out
      do_reset();
      for (int i = 0; i < 5; i++) begin
         start_txn((i == 0) ? 3'b111 : 3'b110, g, go);
         check("t2_seq", go, t2[i]);
         finish_txn(g, 1, 1'b0, DW'($urandom));
      end

      // starvation cap with port 0 and port 1 held high
      do_reset();
      for (int i = 0; i < 10; i++) begin
         start_txn(3'b011, g, go);
         check("t3_seq", go, t3[i]);
         finish_txn(g, 0, 1'b0, DW'($urandom));
      end

      // byte-select write from port 2
      pb[2] = 2'b01; pd[2] = 16'h1234; we[2] = 1'b1;
      start_txn(3'b100, g, go);
      check("t4_we", mem_we, 1);
      finish_txn(g, 3, 1'b1, DW'($urandom));

      // reset while BUSY after round-robin has moved to port 2
      do_reset();
      start_txn(3'b010, g, go);
      finish_txn(g, 0, 1'b1, DW'($urandom));
      start_txn(3'b001, g, go);
      @(posedge clk); #3;
      req = 3'b110; reset = 1'b1;
      #1;
      check("t5_mem_req", mem_req, 0);
      check("t5_ack", ack, 0);
      check("t5_grant", grant, 0);
      @(negedge clk);
      reset = 1'b0; m_starve = 0; m_rr = 1; last_rd = '0;
      start_txn(3'b110, g, go);
      check("t5_regrant", go, 1);
      finish_txn(g, 1, 1'b0, DW'($urandom));

      // spurious mem_ack while IDLE
      @(negedge clk);
      req = '0; mem_ack = 1'b1; mem_rdata = DW'($urandom);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("t6_ack", ack, 0);
         check("t6_mem_req", mem_req, 0);
         check("t6_rdata", rdata, last_rd);
      end
      mem_ack = 1'b0;

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         rand_ports();
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            req = '0; mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("rand_idle_req", mem_req, 0);
            check("rand_idle_ack", ack, 0);
         end
         start_txn(3'($urandom_range(1, 7)), g, go);
         finish_txn(g, $urandom_range(0, 4), 1'($urandom_range(0, 1)), DW'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
